xbar_demux: RTL and testbench
=============================

# xbar_demux

Parametrised 1:N request router between the core's data port and the peripheral devices (RAM, UART, GPIO, and later additions). It replaces the fixed three-device decode with a table of `NumDev` base/mask pairs, and adds the following behaviour:
- tracks outstanding transactions so responses return in order;
- applies back-pressure at a configurable depth;
- answers unmapped addresses from an internal error responder instead of hanging the bus.

## Interface

Parameters:
- `NumDev`, default 3: number of device ports.
- `MaxOutstanding`, default 4: maximum accepted requests without a response (1..255).
- `AddrBase`, default `xbar_pkg::ADDR_BASE`: `logic [NumDev-1:0][31:0]`, device base addresses.
- `AddrMask`, default `xbar_pkg::ADDR_MASK`: `logic [NumDev-1:0][31:0]`, device offset masks.

Ports (clock and reset first):
- `clk_i`  in  1  clock. One clock domain.
- `rst_i`  in  1  synchronous, active-high reset.
- `host_req_valid_i`  in  1  host request valid.
- `host_req_ready_o`  out  1  host request accepted.
- `host_req_addr_i`  in  32  byte address.
- `host_req_we_i`  in  1  write enable.
- `host_req_wdata_i`  in  32  write data.
- `host_req_be_i`  in  4  byte enables.
- `host_rsp_valid_o`  out  1  response valid.
- `host_rsp_ready_i`  in  1  host accepts response.
- `host_rsp_rdata_o`  out  32  read data.
- `host_rsp_err_o`  out  1  error response.
- `dev_req_valid_o`  out  NumDev  per-device request valid.
- `dev_req_ready_i`  in  NumDev  per-device ready.
- `dev_req_addr_o`, `dev_req_we_o`, `dev_req_wdata_o`, `dev_req_be_o`  out  32/1/32/4  broadcast to all devices.
- `dev_rsp_valid_i`  in  NumDev  device response valid.
- `dev_rsp_ready_o`  out  NumDev  device response accept.
- `dev_rsp_rdata_i`  in  NumDev×32  device read data.
- `dev_rsp_err_i`  in  NumDev  device error.

## Operation

- **Decode:** device i hits when `(addr & ~AddrMask[i]) == AddrBase[i]`. The lowest hitting index wins on overlap. No hit selects the error target (index `NumDev`).
- **Request path:** combinational.
  - `dev_req_valid_o[sel] = host_req_valid_i & ~stall`.
  - `host_req_ready_o = dev_req_ready_i[sel] & ~stall`, or `~stall` for the error target.
  - Accept = valid & ready.
- **Stall** is asserted when either:
  - `count == MaxOutstanding`; or
  - `count != 0` and `sel != cur_sel`.

  A stall to a different target holds until `count` drains to 0. This keeps responses in order without a reorder buffer.
- **On accept:** `cur_sel <= sel`.
- **Response path:**
  - Host outputs mux `dev_rsp_*[cur_sel]` when `count != 0`.
  - `dev_rsp_ready_o[cur_sel] = host_rsp_ready_i`.
- **Error target:** each accept to index `NumDev` increments the pending-error counter `err_cnt` (width as `count`). While `err_cnt != 0`, the target presents `rsp_valid=1`, `rdata=32'h0`, `err=1`. Each handshake decrements `err_cnt`.
- **Count:**
  - +1 on accept, −1 on host response handshake.
  - Simultaneous accept and handshake: count unchanged.
  - Width is `$clog2(MaxOutstanding+1)`.
- **Stray responses:** a device response while `count == 0`, or from a port other than `cur_sel`, is consumed (`dev_rsp_ready_o=1`) and discarded. It is never forwarded.
- **Reset** clears `count`, `err_cnt` and `cur_sel` to 0. A reset mid-transaction drops all outstanding tracking. Late device responses are then discarded per the stray-response rule above.

## Timing

- Device request latency: 0 cycles (combinational pass-through).
- Error response: valid no earlier than the cycle after accept. Held until `host_rsp_ready_i`.
- Device response to host: 0 cycles (combinational mux).
- Outputs during reset:
  - `host_rsp_valid_o=0`.
  - `dev_rsp_ready_o` = all-ones (drain).
  - `host_req_ready_o=0`.
  - `dev_req_valid_o=0`.
- Throughput: one accept per cycle to the same target, up to `MaxOutstanding` in flight.

## Structure

- `xbar_pkg` holds:
  - `NumDevices`;
  - per-device localparams;
  - `ADDR_BASE` and `ADDR_MASK` arrays;
  - `typedef logic [$clog2(NumDevices+1)-1:0] dev_idx_t`.
- Sub-module `xbar_err_resp`: error target holding `err_cnt` and its valid/ready response logic.
- Decode is a function in `xbar_pkg` (`xbar_decode`) so the bench can reuse it.

## Test plan

- **Single read:** read 0x1000_0010 with RAM returning 0xDEADBEEF next cycle → `dev_req_valid_o=3'b001`, host gets rdata 0xDEADBEEF, `err=0`, `count` returns to 0.
- **Unmapped:** write to 0x2000_0000 → no `dev_req_valid_o` bit set, accepted in the same cycle. The next cycle gives `host_rsp_valid_o=1`, `err=1`, `rdata=0`.
- **Back-pressure:** `MaxOutstanding=4` with the UART withholding responses, 5 back-to-back reads to 0x4000_0000 → the fifth sees `host_req_ready_o=0` until one UART response handshakes.
- **Target switch:** RAM read outstanding, then a GPIO read to 0x4001_0004 → GPIO valid stays 0 until the RAM response completes, then issues the same cycle `count` hits 0.
- **Simultaneous:** accept and response handshake in the same cycle at `count=2` → `count` stays 2.
- **Reset mid-flight:** 2 RAM reads outstanding, pulse `rst_i` for 1 cycle, then RAM responds → the response is consumed, `host_rsp_valid_o` stays 0, and a following GPIO request proceeds normally.

Source files
------------

// File: rtl/xbar_pkg.sv
// Address map and decode helper shared by the request router and its bench.
package xbar_pkg;

    localparam int NumDevices = 3;

    localparam int DevRam  = 0;
    localparam int DevUart = 1;
    localparam int DevGpio = 2;

    localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
    localparam logic [31:0] RAM_MASK  = 32'h00FF_FFFF;
    localparam logic [31:0] UART_BASE = 32'h4000_0000;
    localparam logic [31:0] UART_MASK = 32'h0000_FFFF;
    localparam logic [31:0] GPIO_BASE = 32'h4001_0000;
    localparam logic [31:0] GPIO_MASK = 32'h0000_FFFF;

    localparam logic [NumDevices-1:0][31:0] ADDR_BASE = {GPIO_BASE, UART_BASE, RAM_BASE};
    localparam logic [NumDevices-1:0][31:0] ADDR_MASK = {GPIO_MASK, UART_MASK, RAM_MASK};

    typedef logic [$clog2(NumDevices+1)-1:0] dev_idx_t;

    // Descending scan so the lowest hitting index wins; index NumDevices means unmapped.
    function automatic dev_idx_t xbar_decode(input logic [31:0] addr);
        dev_idx_t idx;
        idx = dev_idx_t'(NumDevices);
        for (int i = NumDevices - 1; i >= 0; i--) begin
            if ((addr & ~ADDR_MASK[i]) == ADDR_BASE[i]) begin
                idx = dev_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/xbar_err_resp.sv
// Error target for unmapped addresses: counts pending error responses and
// presents an error beat for each one until the host takes it.
module xbar_err_resp #(
    parameter int CntW = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_accept_i,
    input  logic        rsp_ready_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    logic [CntW-1:0] err_cnt;
    logic            rsp_hs;

    assign rsp_valid_o = (err_cnt != '0);
    assign rsp_rdata_o = 32'h0;
    assign rsp_err_o   = 1'b1;
    assign rsp_hs      = rsp_valid_o & rsp_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt <= '0;
        end else if (req_accept_i && !rsp_hs) begin
            err_cnt <= err_cnt + CntW'(1);
        end else if (!req_accept_i && rsp_hs) begin
            err_cnt <= err_cnt - CntW'(1);
        end
    end

endmodule

// File: rtl/xbar_demux.sv
// 1:N request router with in-order response tracking, outstanding-depth
// back-pressure and an internal error target for unmapped addresses.
module xbar_demux
    import xbar_pkg::*;
#(
    parameter int                        NumDev         = 3,
    parameter int                        MaxOutstanding = 4,
    parameter logic [NumDev-1:0][31:0]   AddrBase       = ADDR_BASE,
    parameter logic [NumDev-1:0][31:0]   AddrMask       = ADDR_MASK
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     host_req_valid_i,
    output logic                     host_req_ready_o,
    input  logic [31:0]              host_req_addr_i,
    input  logic                     host_req_we_i,
    input  logic [31:0]              host_req_wdata_i,
    input  logic [3:0]               host_req_be_i,
    output logic                     host_rsp_valid_o,
    input  logic                     host_rsp_ready_i,
    output logic [31:0]              host_rsp_rdata_o,
    output logic                     host_rsp_err_o,
    output logic [NumDev-1:0]        dev_req_valid_o,
    input  logic [NumDev-1:0]        dev_req_ready_i,
    output logic [31:0]              dev_req_addr_o,
    output logic                     dev_req_we_o,
    output logic [31:0]              dev_req_wdata_o,
    output logic [3:0]               dev_req_be_o,
    input  logic [NumDev-1:0]        dev_rsp_valid_i,
    output logic [NumDev-1:0]        dev_rsp_ready_o,
    input  logic [NumDev-1:0][31:0]  dev_rsp_rdata_i,
    input  logic [NumDev-1:0]        dev_rsp_err_i
);

    localparam int              IdxW   = $clog2(NumDev + 1);
    localparam int              CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [IdxW-1:0] ErrIdx = IdxW'(NumDev);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    logic [IdxW-1:0] sel;
    logic [IdxW-1:0] cur_sel;
    logic [CntW-1:0] count;
    logic            busy;
    logic            stall;
    logic            sel_ready;
    logic            accept;
    logic            rsp_hs;
    logic            err_accept;
    logic            err_ready;
    logic            err_valid;
    logic [31:0]     err_rdata;
    logic            err_err;

    assign dev_req_addr_o  = host_req_addr_i;
    assign dev_req_we_o    = host_req_we_i;
    assign dev_req_wdata_o = host_req_wdata_i;
    assign dev_req_be_o    = host_req_be_i;

    assign busy = (count != '0);

    always_comb begin
        sel = ErrIdx;
        for (int i = NumDev - 1; i >= 0; i--) begin
            if ((host_req_addr_i & ~AddrMask[i]) == AddrBase[i]) begin
                sel = IdxW'(i);
            end
        end
    end

    // Switching targets waits for a full drain, which keeps responses in order.
    assign stall = (count == CntMax) || (busy && (sel != cur_sel));

    always_comb begin
        sel_ready       = 1'b1;
        dev_req_valid_o = '0;
        for (int i = 0; i < NumDev; i++) begin
            if (sel == IdxW'(i)) begin
                sel_ready          = dev_req_ready_i[i];
                dev_req_valid_o[i] = host_req_valid_i & ~stall & ~rst_i;
            end
        end
    end

    assign host_req_ready_o = sel_ready & ~stall & ~rst_i;
    assign accept           = host_req_valid_i & host_req_ready_o;
    assign err_accept       = accept && (sel == ErrIdx);

    // Ports not owning the current burst are drained so stray responses vanish.
    always_comb begin
        host_rsp_valid_o = 1'b0;
        host_rsp_rdata_o = 32'h0;
        host_rsp_err_o   = 1'b0;
        dev_rsp_ready_o  = '1;
        err_ready        = 1'b0;
        if (busy && !rst_i) begin
            if (cur_sel == ErrIdx) begin
                host_rsp_valid_o = err_valid;
                host_rsp_rdata_o = err_rdata;
                host_rsp_err_o   = err_err;
                err_ready        = host_rsp_ready_i;
            end
            for (int i = 0; i < NumDev; i++) begin
                if (cur_sel == IdxW'(i)) begin
                    host_rsp_valid_o   = dev_rsp_valid_i[i];
                    host_rsp_rdata_o   = dev_rsp_rdata_i[i];
                    host_rsp_err_o     = dev_rsp_err_i[i];
                    dev_rsp_ready_o[i] = host_rsp_ready_i;
                end
            end
        end
    end

    assign rsp_hs = host_rsp_valid_o & host_rsp_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count   <= '0;
            cur_sel <= '0;
        end else begin
            if (accept) begin
                cur_sel <= sel;
            end
            if (accept && !rsp_hs) begin
                count <= count + CntW'(1);
            end else if (!accept && rsp_hs) begin
                count <= count - CntW'(1);
            end
        end
    end

    xbar_err_resp #(
        .CntW (CntW)
    ) u_err_resp (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_accept_i (err_accept),
        .rsp_ready_i  (err_ready),
        .rsp_valid_o  (err_valid),
        .rsp_rdata_o  (err_rdata),
        .rsp_err_o    (err_err)
    );

endmodule

// File: tb/tb_xbar_demux.sv
// Directed bench for xbar_demux; expected responses go through a scoreboard
// queue popped by an independent response monitor.
module tb_xbar_demux;
    import xbar_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic             req_we;
    logic [31:0]      req_wdata;
    logic [3:0]       req_be;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic [2:0]       dreq_valid;
    logic [2:0]       dreq_ready;
    logic [31:0]      dreq_addr;
    logic             dreq_we;
    logic [31:0]      dreq_wdata;
    logic [3:0]       dreq_be;
    logic [2:0]       drsp_valid;
    logic [2:0]       drsp_ready;
    logic [2:0][31:0] drsp_rdata;
    logic [2:0]       drsp_err;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    always #5 clk = ~clk;

    xbar_demux dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .host_req_valid_i (req_valid),
        .host_req_ready_o (req_ready),
        .host_req_addr_i  (req_addr),
        .host_req_we_i    (req_we),
        .host_req_wdata_i (req_wdata),
        .host_req_be_i    (req_be),
        .host_rsp_valid_o (rsp_valid),
        .host_rsp_ready_i (rsp_ready),
        .host_rsp_rdata_o (rsp_rdata),
        .host_rsp_err_o   (rsp_err),
        .dev_req_valid_o  (dreq_valid),
        .dev_req_ready_i  (dreq_ready),
        .dev_req_addr_o   (dreq_addr),
        .dev_req_we_o     (dreq_we),
        .dev_req_wdata_o  (dreq_wdata),
        .dev_req_be_o     (dreq_be),
        .dev_rsp_valid_i  (drsp_valid),
        .dev_rsp_ready_o  (drsp_ready),
        .dev_rsp_rdata_i  (drsp_rdata),
        .dev_rsp_err_i    (drsp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rsp(input logic err, input logic [31:0] data);
        exp_q.push_back({err, data});
    endtask

    // Response monitor: every host handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e[31:0]);
                check("rsp_err", 32'(rsp_err), 32'(mon_e[32]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_we     = 1'b0;
        req_wdata  = 32'h0;
        req_be     = 4'hF;
        rsp_ready  = 1'b1;
        dreq_ready = 3'b111;
        drsp_valid = 3'b000;
        drsp_rdata = '0;
        drsp_err   = 3'b000;

        // Reset state
        repeat (2) step();
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_dev_rsp_ready", 32'(drsp_ready), 32'h7);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_dev_req_valid", 32'(dreq_valid), 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_count", 32'(dut.count), 32'h0);

        check("decode_ram", 32'(xbar_decode(32'h1000_0010)), 32'h0);
        check("decode_uart", 32'(xbar_decode(32'h4000_0000)), 32'h1);
        check("decode_gpio", 32'(xbar_decode(32'h4001_0004)), 32'h2);
        check("decode_unmapped", 32'(xbar_decode(32'h2000_0000)), 32'h3);

        // Single read to RAM
        step();
        req_addr  = 32'h1000_0010;
        req_we    = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        check("rd_dev_req_valid", 32'(dreq_valid), 32'h1);
        check("rd_req_ready", 32'(req_ready), 32'h1);
        check("rd_dev_req_addr", dreq_addr, 32'h1000_0010);
        push_rsp(1'b0, 32'hDEAD_BEEF);
        step();
        req_valid     = 1'b0;
        drsp_valid    = 3'b001;
        drsp_rdata[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rd_count_busy", 32'(dut.count), 32'h1);
        step();
        drsp_valid = 3'b000;
        @(negedge clk);
        check("rd_count_idle", 32'(dut.count), 32'h0);

        // Unmapped write goes to the error target
        step();
        req_addr  = 32'h2000_0000;
        req_we    = 1'b1;
        req_wdata = 32'h1234_5678;
        req_valid = 1'b1;
        @(negedge clk);
        check("unm_dev_req_valid", 32'(dreq_valid), 32'h0);
        check("unm_req_ready", 32'(req_ready), 32'h1);
        check("unm_rsp_not_early", 32'(rsp_valid), 32'h0);
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        rsp_ready = 1'b0;
        push_rsp(1'b1, 32'h0);
        @(negedge clk);
        check("unm_rsp_valid", 32'(rsp_valid), 32'h1);
        check("unm_rsp_err", 32'(rsp_err), 32'h1);
        check("unm_rsp_rdata", rsp_rdata, 32'h0);
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("unm_rsp_held", 32'(rsp_valid), 32'h1);
        step();
        @(negedge clk);
        check("unm_count_idle", 32'(dut.count), 32'h0);
        check("unm_rsp_cleared", 32'(rsp_valid), 32'h0);

        // Back-pressure at MaxOutstanding with the UART withholding responses
        step();
        req_addr  = 32'h4000_0000;
        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_ready_fill", 32'(req_ready), 32'h1);
            step();
        end
        @(negedge clk);
        check("bp_count_full", 32'(dut.count), 32'h4);
        check("bp_ready_full", 32'(req_ready), 32'h0);
        check("bp_dev_req_valid_full", 32'(dreq_valid), 32'h0);
        step();
        @(negedge clk);
        check("bp_ready_hold", 32'(req_ready), 32'h0);
        step();
        drsp_valid    = 3'b010;
        drsp_rdata[1] = 32'h1111_0000;
        push_rsp(1'b0, 32'h1111_0000);
        @(negedge clk);
        check("bp_ready_during_rsp", 32'(req_ready), 32'h0);
        step();
        drsp_valid = 3'b000;
        @(negedge clk);
        check("bp_ready_released", 32'(req_ready), 32'h1);
        check("bp_dev_req_valid_released", 32'(dreq_valid), 32'h2);
        step();
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drsp_valid    = 3'b010;
            drsp_rdata[1] = 32'h1111_0000 + 32'(k);
            push_rsp(1'b0, 32'h1111_0000 + 32'(k));
            step();
        end
        drsp_valid = 3'b000;
        @(negedge clk);
        check("bp_count_drained", 32'(dut.count), 32'h0);

        // Simultaneous accept and handshake at count 2, then a target switch
        req_addr  = 32'h1000_0020;
        req_valid = 1'b1;
        step();
        step();
        drsp_valid    = 3'b001;
        drsp_rdata[0] = 32'hA000_0001;
        push_rsp(1'b0, 32'hA000_0001);
        @(negedge clk);
        check("sim_count_before", 32'(dut.count), 32'h2);
        check("sim_req_ready", 32'(req_ready), 32'h1);
        step();
        drsp_valid = 3'b000;
        req_addr   = 32'h4001_0004;
        @(negedge clk);
        check("sim_count_after", 32'(dut.count), 32'h2);
        check("sw_dev_req_valid_blocked", 32'(dreq_valid), 32'h0);
        check("sw_req_ready_blocked", 32'(req_ready), 32'h0);
        step();
        drsp_valid    = 3'b001;
        drsp_rdata[0] = 32'hA000_0002;
        push_rsp(1'b0, 32'hA000_0002);
        @(negedge clk);
        check("sw_blocked_2", 32'(dreq_valid), 32'h0);
        step();
        drsp_rdata[0] = 32'hA000_0003;
        push_rsp(1'b0, 32'hA000_0003);
        @(negedge clk);
        check("sw_blocked_1", 32'(dreq_valid), 32'h0);
        step();
        drsp_valid = 3'b000;
        @(negedge clk);
        check("sw_count_zero", 32'(dut.count), 32'h0);
        check("sw_dev_req_valid_gpio", 32'(dreq_valid), 32'h4);
        check("sw_req_ready_gpio", 32'(req_ready), 32'h1);
        step();
        req_valid     = 1'b0;
        drsp_valid    = 3'b100;
        drsp_rdata[2] = 32'h600D_0004;
        push_rsp(1'b0, 32'h600D_0004);
        step();
        drsp_valid = 3'b000;
        @(negedge clk);
        check("sw_count_idle", 32'(dut.count), 32'h0);

        // Reset with two RAM reads outstanding
        req_addr  = 32'h1000_0040;
        req_valid = 1'b1;
        step();
        step();
        req_valid = 1'b0;
        @(negedge clk);
        check("rm_count_before", 32'(dut.count), 32'h2);
        step();
        rst       = 1'b1;
        req_addr  = 32'h4001_0008;
        req_valid = 1'b1;
        @(negedge clk);
        check("rm_req_ready_in_rst", 32'(req_ready), 32'h0);
        check("rm_dev_req_valid_in_rst", 32'(dreq_valid), 32'h0);
        check("rm_dev_rsp_ready_in_rst", 32'(drsp_ready), 32'h7);
        check("rm_rsp_valid_in_rst", 32'(rsp_valid), 32'h0);
        step();
        rst           = 1'b0;
        req_valid     = 1'b0;
        drsp_valid    = 3'b001;
        drsp_rdata[0] = 32'hBAD0_BAD0;
        @(negedge clk);
        check("rm_count_cleared", 32'(dut.count), 32'h0);
        check("rm_stray_not_forwarded", 32'(rsp_valid), 32'h0);
        check("rm_stray_consumed", 32'(drsp_ready), 32'h7);
        step();
        drsp_valid = 3'b000;
        req_valid  = 1'b1;
        @(negedge clk);
        check("rm_gpio_dev_req_valid", 32'(dreq_valid), 32'h4);
        check("rm_gpio_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid     = 1'b0;
        drsp_valid    = 3'b100;
        drsp_rdata[2] = 32'h600D_0008;
        push_rsp(1'b0, 32'h600D_0008);
        step();
        drsp_valid = 3'b000;
        @(negedge clk);
        check("rm_count_final", 32'(dut.count), 32'h0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
